// File: rtl/rv32im_alu.sv
// rv32im_alu: registered RV32I/RV32M execute-stage ALU with zero flag; RV32M ops built only when ALU_MULDIV_EN is defined
//   CLK            rising-edge clock
//   RESET          synchronous active-low reset (RESULT=0, ZERO=1)
//   DATA1, DATA2   operands A/B
//   SELECT         operation code
//   RESULT, ZERO   registered result and RESULT==0 flag, one cycle after the inputs
module rv32im_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [4:0]       SELECT,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO
);
  logic [4:0]       shamt;
  logic [WIDTH-1:0] nxt;
  assign shamt = DATA2[4:0];
`ifdef ALU_MULDIV_EN
  logic signed [WIDTH:0]       a_s, a_u, b_s, b_u;
  logic signed [2*WIDTH+1:0]   p_ss, p_su, p_uu;
  logic                        dz, ovf;
  logic signed [WIDTH-1:0]     sa, sd;
  logic [WIDTH-1:0]            ud, q_s, r_s, q_u, r_u;
  assign a_s  = {DATA1[WIDTH-1], DATA1};
  assign a_u  = {1'b0, DATA1};
  assign b_s  = {DATA2[WIDTH-1], DATA2};
  assign b_u  = {1'b0, DATA2};
  assign p_ss = a_s * b_s;
  assign p_su = a_s * b_u;
  assign p_uu = a_u * b_u;
  assign dz   = DATA2 == '0;
  assign ovf  = DATA1 == {1'b1, {(WIDTH-1){1'b0}}} && DATA2 == '1;
  // Dividing by 1 instead of 0 or -1 keeps the divider defined; overflow then falls out naturally (q=D1, r=0).
  assign sa   = $signed(DATA1);
  assign sd   = (dz || ovf) ? WIDTH'(1) : $signed(DATA2);
  assign ud   = dz ? WIDTH'(1) : DATA2;
  assign q_s  = dz ? '1 : sa / sd;
  assign r_s  = dz ? DATA1 : sa % sd;
  assign q_u  = dz ? '1 : DATA1 / ud;
  assign r_u  = dz ? DATA1 : DATA1 % ud;
`endif
  always_comb begin
    nxt = '0;
    case (SELECT)
      5'd0:  nxt = DATA1 + DATA2;
      5'd1:  nxt = DATA1 - DATA2;
      5'd2:  nxt = DATA1 << shamt;
      5'd3:  nxt = WIDTH'($signed(DATA1) < $signed(DATA2));
      5'd4:  nxt = WIDTH'(DATA1 < DATA2);
      5'd5:  nxt = DATA1 ^ DATA2;
      5'd6:  nxt = DATA1 >> shamt;
      5'd7:  nxt = $unsigned($signed(DATA1) >>> shamt);
      5'd8:  nxt = DATA1 | DATA2;
      5'd9:  nxt = DATA1 & DATA2;
`ifdef ALU_MULDIV_EN
      5'd10: nxt = p_uu[WIDTH-1:0];
      5'd11: nxt = p_ss[2*WIDTH-1:WIDTH];
      5'd12: nxt = p_su[2*WIDTH-1:WIDTH];
      5'd13: nxt = p_uu[2*WIDTH-1:WIDTH];
      5'd14: nxt = q_s;
      5'd15: nxt = q_u;
      5'd16: nxt = r_s;
      5'd17: nxt = r_u;
`endif
      5'd18: nxt = DATA2;
      default: nxt = '0;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      RESULT <= '0;
      ZERO   <= 1'b1;
    end else begin
      RESULT <= nxt;
      ZERO   <= nxt == '0;
    end
  end
endmodule

// File: tb/tb_rv32im_alu.sv
// tb_rv32im_alu: scoreboard bench for rv32im_alu with directed, hand-computed vectors
module tb_rv32im_alu;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] DATA1 = '0, DATA2 = '0;
  logic [4:0]  SELECT = '0;
  logic [31:0] RESULT;
  logic        ZERO;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  rv32im_alu dut (
    .CLK(CLK), .RESET(RESET), .DATA1(DATA1), .DATA2(DATA2),
    .SELECT(SELECT), .RESULT(RESULT), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] m(input logic [31:0] v);
    return MD ? v : 32'h0;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] s,
                       input logic [31:0] e, input string name);
    exp_t x;
    DATA1 = a;
    DATA2 = b;
    SELECT = s;
    @(posedge CLK);
    x.res = e;
    x.zero = (e == 32'h0);
    x.name = name;
    exp_q.push_back(x);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        checks++;
        if (RESULT !== x.res || ZERO !== x.zero) begin
          errors++;
          $display("FAIL %s: got RESULT=%h ZERO=%b, expected RESULT=%h ZERO=%b",
                   x.name, RESULT, ZERO, x.res, x.zero);
        end
      end
    end
  end

  initial begin
    RESET = 1'b0;
    issue(32'd5, 32'd2, 5'd0, 32'h0, "reset_hold0");
    issue(32'd5, 32'd2, 5'd0, 32'h0, "reset_hold1");
    RESET = 1'b1;
    issue(32'd5, 32'd2, 5'd0, 32'd7, "reset_release_add");
    issue(32'd1, 32'd2, 5'd0, 32'd3, "add_1_2");
    issue(32'd5, 32'd2, 5'd0, 32'd7, "add_5_2");
    issue(32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, "add_wrap");
    issue(32'd5, 32'd7, 5'd1, 32'hFFFF_FFFE, "sub_neg");
    issue(32'd5, 32'd5, 5'd1, 32'h0, "sub_zero");
    issue(32'd1, 32'h24, 5'd2, 32'h10, "sll_mask");
    issue(32'hFFFF_FFFF, 32'd1, 5'd3, 32'd1, "slt");
    issue(32'hFFFF_FFFF, 32'd1, 5'd4, 32'd0, "sltu");
    issue(32'h0000_F0F0, 32'h0000_FF00, 5'd5, 32'h0000_0FF0, "xor");
    issue(32'h8000_0000, 32'd1, 5'd6, 32'h4000_0000, "srl");
    issue(32'h8000_0000, 32'h21, 5'd7, 32'hC000_0000, "sra_mask");
    issue(32'h0000_F0F0, 32'h0000_FF00, 5'd8, 32'h0000_FFF0, "or");
    issue(32'h0000_F0F0, 32'h0000_FF00, 5'd9, 32'h0000_F000, "and");
    issue(32'd3, 32'd4, 5'd10, m(32'd12), "mul");
    issue(32'hFFFF_FFFF, 32'd2, 5'd10, m(32'hFFFF_FFFE), "mul_wrap");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, m(32'h0), "mulh");
    issue(32'hFFFF_FFFF, 32'd2, 5'd12, m(32'hFFFF_FFFF), "mulhsu");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, m(32'hFFFF_FFFE), "mulhu");
    issue(32'd4, 32'hFFFF_FFFE, 5'd14, m(32'hFFFF_FFFE), "div_4_m2");
    issue(32'hFFFF_FFF9, 32'd2, 5'd16, m(32'hFFFF_FFFF), "rem_m7_2");
    issue(32'd5, 32'd0, 5'd14, m(32'hFFFF_FFFF), "div_by0");
    issue(32'd5, 32'd0, 5'd15, m(32'hFFFF_FFFF), "divu_by0");
    issue(32'd5, 32'd0, 5'd16, m(32'd5), "rem_by0");
    issue(32'd5, 32'd0, 5'd17, m(32'd5), "remu_by0");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 5'd14, m(32'h8000_0000), "div_ovf");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 5'd16, m(32'h0), "rem_ovf");
    issue(32'd7, 32'd2, 5'd15, m(32'd3), "divu");
    issue(32'd7, 32'd2, 5'd17, m(32'd1), "remu");
    issue(32'h0, 32'h1234_5000, 5'd18, 32'h1234_5000, "fwd");
    issue(32'd3, 32'd4, 5'd25, 32'h0, "rsv25");
    issue(32'd3, 32'd4, 5'd19, 32'h0, "rsv19");
    issue(32'd3, 32'd4, 5'd31, 32'h0, "rsv31");
    issue(32'd9, 32'd9, 5'd0, 32'd18, "pre_midreset");
    RESET = 1'b0;
    issue(32'd9, 32'd9, 5'd0, 32'h0, "midreset");
    RESET = 1'b1;
    issue(32'd9, 32'd9, 5'd0, 32'd18, "post_midreset");
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32im_alu.md
Name: rv32im_alu

Overview:
- Execute-stage arithmetic/logic unit for the RV32IM pipeline.
- Takes two 32-bit operands and a 5-bit operation select, computes one RV32I base or RV32M multiply/divide result, and registers it on the clock edge.
- Output feeds the EX/MEM pipeline register path and the branch-compare logic (ZERO flag).

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported for RV32IM.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-low reset; sampled on rising CLK.
- DATA1  input  32  operand A (rs1 / PC), two's-complement.
- DATA2  input  32  operand B (rs2 / immediate), two's-complement.
- SELECT  input  5  operation code, see Behaviour.
- RESULT  output  32  registered operation result.
- ZERO  output  1  registered flag, 1 when the registered RESULT == 0.

Behaviour:
- Reset: when RESET==0 at a rising CLK edge, RESULT<=0 and ZERO<=1. Reset overrides any operation in the same cycle. Reset mid-stream discards the in-flight computation.
- Latency: exactly 1 cycle. Inputs sampled at edge N, so RESULT/ZERO are valid after edge N. No handshake; a new operation is accepted every cycle. RESULT holds until the next edge.
- SELECT encoding:
  - 0 ADD: D1+D2, mod 2^32.
  - 1 SUB: D1-D2, mod 2^32.
  - 2 SLL: D1 << D2[4:0].
  - 3 SLT: signed D1<D2 gives 1, else 0.
  - 4 SLTU: unsigned D1<D2 gives 1, else 0.
  - 5 XOR, 8 OR, 9 AND: bitwise.
  - 6 SRL: logical D1 >> D2[4:0].
  - 7 SRA: arithmetic D1 >>> D2[4:0].
  - 10 MUL: low 32 bits of D1*D2.
  - 11 MULH: high 32 bits of signed×signed.
  - 12 MULHSU: high 32 bits of signed D1 × unsigned D2.
  - 13 MULHU: high 32 bits of unsigned×unsigned.
  - 14 DIV: signed quotient, truncated toward zero.
  - 15 DIVU: unsigned quotient.
  - 16 REM: signed remainder; sign follows the dividend.
  - 17 REMU: unsigned remainder.
  - 18 FWD: passes D2 through (LUI).
  - 19–31: reserved, result 0.
- Shifts use only D2[4:0]; D2[31:5] are ignored.
- Divide by zero (D2==0): DIV gives 0xFFFFFFFF, DIVU gives 0xFFFFFFFF, REM gives D1, REMU gives D1.
- Signed overflow (D1==0x80000000, D2==0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- Multiply/divide are combinational within the single cycle; no stall output.
- ZERO is computed from the same next-state value as RESULT, so it is always consistent with RESULT.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: SELECT codes 10–17 implement the RV32M operations above.
- Undefined: multiply/divide hardware is omitted, and codes 10–17 behave as reserved (RESULT 0, ZERO 1). All other codes are unchanged.

Test Plan:
- Reset: RESET=0 for 2 edges with D1=5, D2=2, SELECT=0 -> RESULT=0, ZERO=1. Release RESET, next edge -> RESULT=7, ZERO=0.
- Add sequence: (1,2,SEL 0) then (5,2,SEL 0) -> RESULT 3 then 7, each one cycle after its inputs.
- Signed divide (ALU_MULDIV_EN): (4,-2,SEL 14) -> RESULT=-2 (0xFFFFFFFE). (-7,2,SEL 16) -> RESULT=-1.
- Corner divides: (5,0,SEL 14) -> 0xFFFFFFFF. (5,0,SEL 17) -> 5. (0x80000000,-1,SEL 14) -> 0x80000000. (0x80000000,-1,SEL 16) -> 0.
- Shifts/compares:
  - (0x80000000,0x21,SEL 7) -> 0xC0000000 (shift amount 1).
  - (0x80000000,1,SEL 6) -> 0x40000000.
  - (-1,1,SEL 3) -> 1.
  - (-1,1,SEL 4) -> 0.
- Multiply high and reserved codes:
  - (-1,-1,SEL 13) -> 0xFFFFFFFE.
  - (-1,-1,SEL 11) -> 0.
  - (-1,2,SEL 12) -> 0xFFFFFFFF.
  - (3,4,SEL 25) -> RESULT 0, ZERO 1.
  - Without ALU_MULDIV_EN, (4,-2,SEL 14) -> 0.
